// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, flag bit
// positions and FSM state encoding.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'd0,
      OP_OR   = 4'd1,
      OP_XOR  = 4'd2,
      OP_NOT  = 4'd3,
      OP_ANDN = 4'd4,
      OP_ORN  = 4'd5,
      OP_XNOR = 4'd6,
      OP_ADD  = 4'd7,
      OP_SUB  = 4'd8,
      OP_MUL  = 4'd9,
      OP_DIV  = 4'd10,
      OP_SHL  = 4'd11,
      OP_SHR  = 4'd12
   } op_e;

   localparam int FLG_ZERO    = 0;
   localparam int FLG_CARRY   = 1;
   localparam int FLG_OVF     = 2;
   localparam int FLG_DZ      = 3;
   localparam int FLG_ILLEGAL = 4;
   localparam int NFLG        = 5;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bus of alu_seq: input and output valid/ready channels.
interface alu_seq_if #(parameter int W = 8);
   import alu_seq_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic [3:0]      opcode;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    res;
   logic [W-1:0]    res_hi;
   logic [NFLG-1:0] flags;

   modport master (
      output in_valid, a, b, opcode, out_ready,
      input  in_ready, out_valid, res, res_hi, flags
   );

   modport slave (
      input  in_valid, a, b, opcode, out_ready,
      output in_ready, out_valid, res, res_hi, flags
   );

endinterface

// File: rtl/alu_seq_div.sv
// Unsigned restoring divider, one quotient bit per clock. done_o is high in
// the cycle the final bit is computed; quot_o/rem_o then hold the result.
module alu_seq_div #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [W-1:0] dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic         done_o,
   output logic [W-1:0] quot_o,
   output logic [W-1:0] rem_o
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   logic          busy_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  quot_q;
   logic [W-1:0]  rem_q;
   logic [W-1:0]  dvsr_q;
   logic [W:0]    rem_sh;
   logic [W:0]    trial;

   // A set MSB in the trial difference means the subtraction went negative.
   always_comb begin
      rem_sh = {rem_q, quot_q[W-1]};
      trial  = rem_sh - {1'b0, dvsr_q};
      if (trial[W]) begin
         rem_o  = rem_sh[W-1:0];
         quot_o = {quot_q[W-2:0], 1'b0};
      end else begin
         rem_o  = trial[W-1:0];
         quot_o = {quot_q[W-2:0], 1'b1};
      end
   end

   assign done_o = busy_q & (cnt_q == CW'(W-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dvsr_q <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         quot_q <= dividend_i;
         rem_q  <= '0;
         dvsr_q <= divisor_i;
      end else if (busy_q) begin
         quot_q <= quot_o;
         rem_q  <= rem_o;
         cnt_q  <= cnt_q + 1'b1;
         if (done_o) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Clocked W-bit ALU with valid/ready handshake and a multi-cycle divider.
// Build option: ALU_SEQ_MUL_EN enables opcode 9 (MUL); otherwise it is illegal.
//
// state | meaning
// IDLE  | waiting for an operation
// BUSY  | divider iterating
// DONE  | result presented, waiting for out_ready
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int W   = 8,
   parameter int SHW = $clog2(W)
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus
);
   logic [1:0]      state_q, state_d;
   logic [W-1:0]    res_q, res_d;
   logic [W-1:0]    hi_q, hi_d;
   logic [NFLG-1:0] flg_q, flg_d;

   logic [W-1:0]    a_w, b_w;
   logic            in_ready_w, accept, div_start;
   logic [W-1:0]    sc_res, sc_hi;
   logic [NFLG-1:0] sc_flg;
   logic            carry, ovf, dz, ill;
   logic            div_done;
   logic [W-1:0]    div_q, div_r;

   assign a_w        = bus.a;
   assign b_w        = bus.b;
   assign in_ready_w = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
   assign accept     = bus.in_valid & in_ready_w;
   assign div_start  = accept & (bus.opcode == OP_DIV) & (b_w != '0);

`ifdef ALU_SEQ_MUL_EN
   logic [2*W-1:0]  prod;
   assign prod = {{W{1'b0}}, a_w} * {{W{1'b0}}, b_w};
`endif

   // Shifts by b >= W fall out of the (W+1)-bit window and give zero;
   // the extra bit captures the last bit shifted out.
   always_comb begin
      sc_res = '0;
      sc_hi  = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      dz     = 1'b0;
      ill    = 1'b0;
      case (bus.opcode)
         OP_AND:  sc_res = a_w & b_w;
         OP_OR:   sc_res = a_w | b_w;
         OP_XOR:  sc_res = a_w ^ b_w;
         OP_NOT:  sc_res = ~a_w;
         OP_ANDN: sc_res = ~a_w & b_w;
         OP_ORN:  sc_res = ~a_w | b_w;
         OP_XNOR: sc_res = ~(a_w ^ b_w);
         OP_ADD: begin
            {carry, sc_res} = {1'b0, a_w} + {1'b0, b_w};
            ovf = (a_w[W-1] ~^ b_w[W-1]) & (sc_res[W-1] ^ a_w[W-1]);
         end
         OP_SUB: begin
            {carry, sc_res} = {1'b0, a_w} - {1'b0, b_w};
            ovf = (a_w[W-1] ^ b_w[W-1]) & (sc_res[W-1] ^ a_w[W-1]);
         end
`ifdef ALU_SEQ_MUL_EN
         OP_MUL: begin
            {sc_hi, sc_res} = prod;
            carry = |prod[2*W-1:W];
         end
`endif
         OP_DIV: begin
            sc_res = '1;
            sc_hi  = a_w;
            dz     = 1'b1;
         end
         OP_SHL:  {carry, sc_res} = {1'b0, a_w} << b_w;
         OP_SHR:  {sc_res, carry} = {a_w, 1'b0} >> b_w;
         default: ill = 1'b1;
      endcase
      sc_flg              = '0;
      sc_flg[FLG_ZERO]    = (sc_res == '0);
      sc_flg[FLG_CARRY]   = carry;
      sc_flg[FLG_OVF]     = ovf;
      sc_flg[FLG_DZ]      = dz;
      sc_flg[FLG_ILLEGAL] = ill;
   end

   alu_seq_div #(.W(W)) u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (div_start),
      .dividend_i (a_w),
      .divisor_i  (b_w),
      .done_o     (div_done),
      .quot_o     (div_q),
      .rem_o      (div_r)
   );

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      hi_d    = hi_q;
      flg_d   = flg_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               if (div_start) begin
                  state_d = BUSY;
               end else begin
                  state_d = DONE;
                  res_d   = sc_res;
                  hi_d    = sc_hi;
                  flg_d   = sc_flg;
               end
            end else if ((state_q == DONE) && bus.out_ready) begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (div_done) begin
               state_d         = DONE;
               res_d           = div_q;
               hi_d            = div_r;
               flg_d           = '0;
               flg_d[FLG_ZERO] = (div_q == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         res_q   <= '0;
         hi_q    <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         flg_q   <= flg_d;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = (state_q == DONE);
   assign bus.res       = res_q;
   assign bus.res_hi    = hi_q;
   assign bus.flags     = flg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (W=8): directed corner cases, then random ops
// with random gaps and random out_ready, checked against an arithmetic model.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 8;
   localparam int M = 1 << W;

   logic clk = 1'b0;
   logic rst = 1'b1;

   alu_seq_if #(.W(W)) bus();

   alu_seq #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic [4:0]   flg;
      int           due;
      bit           seen;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   ordy_rand = 1'b0;
   bit   ordy_val  = 1'b1;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the opcode definitions.
   function automatic void model(input int op, input int a, input int b,
                                 output exp_t e, output int lat);
      int r, h, t, sa, sb;
      bit c, v, dz, il;
      r = 0; h = 0; c = 0; v = 0; dz = 0; il = 0; lat = 1;
      sa = (a >= M/2) ? a - M : a;
      sb = (b >= M/2) ? b - M : b;
      case (op)
         0: r = a & b;
         1: r = a | b;
         2: r = a ^ b;
         3: r = (~a) & (M-1);
         4: r = (~a) & b;
         5: r = ((~a) | b) & (M-1);
         6: r = (~(a ^ b)) & (M-1);
         7: begin
            t = a + b; r = t % M; c = (t >= M);
            t = sa + sb; v = (t > M/2-1) || (t < -M/2);
         end
         8: begin
            r = (a - b + M) % M; c = (a < b);
            t = sa - sb; v = (t > M/2-1) || (t < -M/2);
         end
`ifdef ALU_SEQ_MUL_EN
         9: begin
            t = a * b; r = t % M; h = t / M; c = (h != 0);
         end
`endif
         10: begin
            if (b == 0) begin
               r = M-1; h = a; dz = 1;
            end else begin
               r = a / b; h = a % b; lat = W + 1;
            end
         end
         11: begin
            if (b == 0) r = a;
            else if (b <= W) begin
               t = a << b; r = t % M; c = ((t >> W) & 1) != 0;
            end
         end
         12: begin
            if (b == 0) r = a;
            else if (b <= W) begin
               r = a >> b; c = ((a >> (b-1)) & 1) != 0;
            end
         end
         default: il = 1;
      endcase
      e.res  = r[W-1:0];
      e.hi   = h[W-1:0];
      e.flg  = {il, dz, v, c, (r == 0)};
      e.seen = 1'b0;
      e.due  = 0;
   endfunction

   // Block should accept whenever nothing is in flight, or the pending result
   // is on the bus and being taken this cycle.
   function automatic bit exp_rdy();
      if (sbq.size() == 0) return 1'b1;
      return (cyc >= sbq[0].due) && bus.out_ready;
   endfunction

   task automatic drive_cycle(input bit v, input logic [3:0] op,
                              input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.in_valid  = v;
      bus.opcode    = op;
      bus.a         = a;
      bus.b         = b;
      bus.out_ready = ordy_rand ? 1'($urandom_range(0, 1)) : ordy_val;
      #1;
      chk("in_ready", bus.in_ready, exp_rdy());
   endtask

   task automatic send(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int waits);
      exp_t e;
      int   lat;
      bit   acc;
      acc   = 1'b0;
      waits = 0;
      while (!acc) begin
         drive_cycle(1'b1, op, a, b);
         if (bus.in_ready) acc = 1'b1;
         else begin
            waits++;
            if (waits > 60) begin
               chk("accept_timeout", 0, 1);
               bus.in_valid = 1'b0;
               return;
            end
         end
      end
      model(int'(op), int'(a), int'(b), e, lat);
      e.due = cyc + lat;
      sbq.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive_cycle(1'b0, 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
   endtask

   task automatic drain();
      int n;
      n = 0;
      ordy_rand = 1'b0;
      ordy_val  = 1'b1;
      while (sbq.size() != 0 && n < 60) begin
         idle(1);
         n++;
      end
      if (sbq.size() != 0) begin
         chk("drain_timeout", sbq.size(), 0);
         sbq.delete();
      end
   endtask

   // Monitor: compares the presented result against the queue head every
   // cycle it is valid, so a held result must stay identical until taken.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (bus.out_valid) begin
               if (sbq.size() == 0) chk("unexpected_out_valid", 1, 0);
               else begin
                  if (!sbq[0].seen) begin
                     chk("latency", cyc, sbq[0].due);
                     sbq[0].seen = 1'b1;
                  end
                  chk("res", bus.res, sbq[0].res);
                  chk("res_hi", bus.res_hi, sbq[0].hi);
                  chk("flags", bus.flags, sbq[0].flg);
                  if (bus.out_ready) void'(sbq.pop_front());
               end
            end else if (sbq.size() != 0 && cyc >= sbq[0].due) begin
               chk("late_out_valid", 0, 1);
               void'(sbq.pop_front());
            end
         end
      end
   end

   initial begin
      int w;
      logic [3:0]   op;
      logic [W-1:0] ra, rb;

      bus.in_valid  = 1'b0;
      bus.opcode    = '0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_res", bus.res, 0);
      chk("rst_res_hi", bus.res_hi, 0);
      chk("rst_flags", bus.flags, 0);
      chk("rst_in_ready", bus.in_ready, 1);

      // Directed: single-cycle ops back to back at full rate.
      ordy_rand = 1'b0;
      ordy_val  = 1'b1;
      send(OP_ADD, 8'hF0, 8'h20, w); chk("b2b_add", w, 0);
      send(OP_SUB, 8'h80, 8'h01, w); chk("b2b_sub1", w, 0);
      send(OP_SUB, 8'h01, 8'h02, w); chk("b2b_sub2", w, 0);
      send(4'd14,  8'h5A, 8'hA5, w); chk("b2b_illegal", w, 0);
      send(OP_SHL, 8'h81, 8'h01, w); chk("b2b_shl", w, 0);
      send(OP_DIV, 8'd200, 8'd7, w); chk("b2b_div", w, 0);
      send(OP_DIV, 8'd200, 8'd0, w); chk("div_busy_waits", w, W);
      send(OP_MUL, 8'hFF, 8'hFF, w); chk("after_dz_wait", w, 0);
      drain();

      // Held result: out_ready low for several cycles, then taken while the
      // next op is accepted in the same cycle.
      ordy_val = 1'b0;
      send(OP_ADD, 8'h12, 8'h34, w);
      idle(6);
      ordy_val = 1'b1;
      send(OP_XOR, 8'hFF, 8'h0F, w); chk("accept_on_release", w, 0);
      drain();

      // Reset three cycles into a divide aborts it without output.
      send(OP_DIV, 8'd200, 8'd7, w);
      idle(2);
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      sbq.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_res", bus.res, 0);
      chk("abort_res_hi", bus.res_hi, 0);
      chk("abort_flags", bus.flags, 0);
      chk("abort_in_ready", bus.in_ready, 1);
      idle(W + 3);

      // Random phase.
      ordy_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         ra = W'($urandom);
         if (op == OP_SHL || op == OP_SHR) rb = W'($urandom_range(0, W + 2));
         else if ($urandom_range(0, 7) == 0) rb = '0;
         else rb = W'($urandom);
         send(op, ra, rb, w);
         idle($urandom_range(0, 2));
      end
      drain();
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
